// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and recovered-timing outputs of the VGA sync monitor.
// master = the sync source / consumer side, slave = the monitor itself.
interface vga_sync_monitor_if;
   logic        h_sync_in;
   logic        v_sync_in;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on;
   logic        locked;
   logic        frame_start;
   logic        timing_err;
   logic [11:0] h_total_meas;
   logic [11:0] h_pulse_meas;
   logic [10:0] v_total_meas;
   logic [10:0] v_pulse_meas;

   modport master (
      output h_sync_in, v_sync_in,
      input  pixel_x, pixel_y, video_on, locked, frame_start, timing_err,
      input  h_total_meas, h_pulse_meas, v_total_meas, v_pulse_meas
   );

   modport slave (
      input  h_sync_in, v_sync_in,
      output pixel_x, pixel_y, video_on, locked, frame_start, timing_err,
      output h_total_meas, h_pulse_meas, v_total_meas, v_pulse_meas
   );
endinterface

// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: measures incoming hsync/vsync geometry, checks it
// against the expected timing, tracks lock and regenerates pixel
// coordinates plus the active-video flag from the sync edges.
module vga_sync_monitor #(
   parameter int H_VIDEO     = 640,
   parameter int H_FRONTP    = 24,
   parameter int H_PULSE     = 96,
   parameter int H_BACKP     = 40,
   parameter int V_VIDEO     = 480,
   parameter int V_FRONTP    = 7,
   parameter int V_PULSE     = 2,
   parameter int V_BACKP     = 35,
   parameter int LOCK_FRAMES = 2,
   parameter int H_TIMEOUT   = 4095
) (
   input logic                clk_0,
   input logic                rst,
   vga_sync_monitor_if.slave  vif
);

   localparam logic [11:0] H_TOT  = 12'(H_VIDEO + H_FRONTP + H_PULSE + H_BACKP);
   localparam logic [11:0] H_PW   = 12'(H_PULSE);
   localparam logic [11:0] H_ACT0 = 12'(H_PULSE + H_BACKP);
   localparam logic [11:0] H_ACT1 = 12'(H_PULSE + H_BACKP + H_VIDEO);
   localparam logic [11:0] H_TO   = 12'(H_TIMEOUT);
   localparam logic [10:0] V_TOT  = 11'(V_VIDEO + V_FRONTP + V_PULSE + V_BACKP);
   localparam logic [10:0] V_PW   = 11'(V_PULSE);
   localparam logic [10:0] V_ACT0 = 11'(V_PULSE + V_BACKP);
   localparam logic [10:0] V_ACT1 = 11'(V_PULSE + V_BACKP + V_VIDEO);
   localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t state, state_n;
   logic [3:0]  good_cnt, good_cnt_n;

   logic        hs_prev, vs_prev;
   logic        h_seen, v_seen;
   logic        to_armed, frame_bad;
   logic [11:0] cnt_h;
   logic [10:0] cnt_v;

   logic        hs_fall, hs_rise, vs_fall, vs_rise;
   logic [11:0] n_cur, h_tot_new;
   logic [10:0] m_cur, v_tot_new;
   logic        err_htot, err_hpw, err_vtot, err_vpw, err_to, err_any;
   logic        frame_close, active, lock_next;

   // Edge detection, current line/frame offsets and violation checks for this sample.
   always_comb begin
      hs_fall   = hs_prev & ~vif.h_sync_in;
      // A rising edge only means something once a falling edge has opened the pulse.
      hs_rise   = ~hs_prev & vif.h_sync_in & h_seen;
      // Vsync is only looked at on hsync falling-edge cycles.
      vs_fall   = hs_fall & vs_prev & ~vif.v_sync_in;
      vs_rise   = hs_fall & ~vs_prev & vif.v_sync_in & v_seen;

      h_tot_new = (cnt_h == 12'hFFF) ? cnt_h : cnt_h + 12'd1;
      v_tot_new = (cnt_v == 11'h7FF) ? cnt_v : cnt_v + 11'd1;
      n_cur     = hs_fall ? 12'd0 : h_tot_new;
      m_cur     = vs_fall ? 11'd0 : (hs_fall ? v_tot_new : cnt_v);

      err_htot  = hs_fall & h_seen & (h_tot_new != H_TOT);
      err_hpw   = hs_rise & (n_cur != H_PW);
      err_vtot  = vs_fall & v_seen & (v_tot_new != V_TOT);
      err_vpw   = vs_rise & (m_cur != V_PW);
      // An hsync edge on the same cycle always beats the timeout.
      err_to    = to_armed & ~hs_fall & (n_cur == H_TO);
      err_any   = err_htot | err_hpw | err_vtot | err_vpw | err_to;

      // The first vsync fall after reset only opens a frame.
      frame_close = vs_fall & v_seen;
      active      = (n_cur >= H_ACT0) && (n_cur < H_ACT1) &&
                    (m_cur >= V_ACT0) && (m_cur < V_ACT1);
   end

   // Lock state and good-frame counter register.
   always_ff @(posedge clk_0) begin
      if (!rst) begin
         state    <= UNLOCKED;
         good_cnt <= 4'd0;
      end else begin
         state    <= state_n;
         good_cnt <= good_cnt_n;
      end
   end

   // Lock next state: any error drops lock and wins over a frame close.
   always_comb begin
      state_n    = state;
      good_cnt_n = good_cnt;
      if (err_any) begin
         state_n    = UNLOCKED;
         good_cnt_n = 4'd0;
      end else if (frame_close && !frame_bad) begin
         good_cnt_n = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
         if (good_cnt_n >= LOCK_N) begin
            state_n = LOCKED;
         end
      end
   end

   // Lock outputs: registered lock flag plus the look-ahead used to gate video.
   always_comb begin
      vif.locked = (state == LOCKED);
      lock_next  = (state_n == LOCKED);
   end

   // Sync history, counters, measurements and registered video outputs.
   always_ff @(posedge clk_0) begin
      if (!rst) begin
         hs_prev          <= 1'b0;
         vs_prev          <= 1'b0;
         h_seen           <= 1'b0;
         v_seen           <= 1'b0;
         to_armed         <= 1'b1;
         frame_bad        <= 1'b0;
         cnt_h            <= 12'd0;
         cnt_v            <= 11'd0;
         vif.h_total_meas <= 12'd0;
         vif.h_pulse_meas <= 12'd0;
         vif.v_total_meas <= 11'd0;
         vif.v_pulse_meas <= 11'd0;
         vif.timing_err   <= 1'b0;
         vif.frame_start  <= 1'b0;
         vif.pixel_x      <= 10'd0;
         vif.pixel_y      <= 10'd0;
         vif.video_on     <= 1'b0;
      end else begin
         hs_prev <= vif.h_sync_in;
         cnt_h   <= n_cur;
         cnt_v   <= m_cur;
         if (hs_fall) begin
            vs_prev <= vif.v_sync_in;
            h_seen  <= 1'b1;
         end
         if (vs_fall) begin
            v_seen <= 1'b1;
         end
         // One timeout per loss episode; the next hsync fall re-arms it.
         if (hs_fall) begin
            to_armed <= 1'b1;
         end else if (err_to) begin
            to_armed <= 1'b0;
         end
         // A frame with any error in it is never counted toward lock.
         if (vs_fall) begin
            frame_bad <= 1'b0;
         end else if (err_any) begin
            frame_bad <= 1'b1;
         end
         if (hs_fall && h_seen) begin
            vif.h_total_meas <= h_tot_new;
         end
         if (hs_rise) begin
            vif.h_pulse_meas <= n_cur;
         end
         if (frame_close) begin
            vif.v_total_meas <= v_tot_new;
         end
         if (vs_rise) begin
            vif.v_pulse_meas <= m_cur;
         end
         vif.timing_err  <= err_any;
         vif.frame_start <= vs_fall;
         vif.video_on    <= active & lock_next;
         vif.pixel_x     <= active ? 10'(n_cur - H_ACT0) : 10'd0;
         vif.pixel_y     <= active ? 10'(m_cur - V_ACT0) : 10'd0;
      end
   end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced geometry:
// 25-clock lines (4 pulse, 3 back porch, 16 active, 2 front porch) and
// 11-line frames (2 pulse, 2 back porch, 6 active, 1 front porch).
module tb_vga_sync_monitor;

   localparam int HP = 4;

   logic clk_0 = 1'b0;
   logic rst   = 1'b0;
   vga_sync_monitor_if vif ();

   vga_sync_monitor #(
      .H_VIDEO(16), .H_FRONTP(2), .H_PULSE(4), .H_BACKP(3),
      .V_VIDEO(6),  .V_FRONTP(1), .V_PULSE(2), .V_BACKP(2),
      .LOCK_FRAMES(2), .H_TIMEOUT(4095)
   ) dut (
      .clk_0 (clk_0),
      .rst   (rst),
      .vif   (vif)
   );

   always #5 clk_0 = ~clk_0;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int line_t0 = 0;
   int cur_line = 0;

   int err_cnt, err_off, err_drop, fs_cnt, lock_hi, lock_rise_at;
   int von_cnt, rises, run, bad_runs, first_off, last_off;
   int rise_px, last_px, py_first, py_last, first_line, last_line, zero_bad;
   bit lock_q = 1'b0;
   bit von_q  = 1'b0;

   task automatic chk_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      @(posedge clk_0);
      err_cnt = 0; err_off = -1; err_drop = 0; fs_cnt = 0; lock_hi = 0; lock_rise_at = 0;
      von_cnt = 0; rises = 0; run = 0; bad_runs = 0; first_off = -1; last_off = -1;
      rise_px = -1; last_px = -1; py_first = -1; py_last = -1;
      first_line = -1; last_line = -1; zero_bad = 0;
   endtask

   task automatic tick(input bit hs, input bit vs);
      @(negedge clk_0);
      vif.h_sync_in = hs;
      vif.v_sync_in = vs;
   endtask

   task automatic run_line(input int len, input bit vs);
      for (int i = 0; i < len; i++) begin
         @(negedge clk_0);
         if (i == 0) line_t0 = cyc;
         vif.h_sync_in = (i < HP) ? 1'b0 : 1'b1;
         vif.v_sync_in = vs;
      end
   endtask

   task automatic run_lines(input int first, input int last, input int stretch, input int vpw);
      for (int l = first; l <= last; l++) begin
         cur_line = l;
         run_line((l == stretch) ? 26 : 25, (l < vpw) ? 1'b0 : 1'b1);
      end
   endtask

   task automatic chk_all_zero(input string pfx);
      chk_eq({pfx, "_locked"},      int'(vif.locked), 0);
      chk_eq({pfx, "_video_on"},    int'(vif.video_on), 0);
      chk_eq({pfx, "_pixel_x"},     int'(vif.pixel_x), 0);
      chk_eq({pfx, "_pixel_y"},     int'(vif.pixel_y), 0);
      chk_eq({pfx, "_timing_err"},  int'(vif.timing_err), 0);
      chk_eq({pfx, "_frame_start"}, int'(vif.frame_start), 0);
      chk_eq({pfx, "_h_total"},     int'(vif.h_total_meas), 0);
      chk_eq({pfx, "_h_pulse"},     int'(vif.h_pulse_meas), 0);
      chk_eq({pfx, "_v_total"},     int'(vif.v_total_meas), 0);
      chk_eq({pfx, "_v_pulse"},     int'(vif.v_pulse_meas), 0);
   endtask

   initial forever begin
      @(posedge clk_0);
      cyc++;
   end

   // Output observer: counts pulses and records where video_on starts and ends.
   initial forever begin
      @(negedge clk_0);
      if (vif.timing_err === 1'b1) begin
         err_cnt++;
         err_off  = cyc - line_t0 - 1;
         err_drop = (lock_q && vif.locked === 1'b0) ? 1 : 0;
      end
      if (vif.frame_start === 1'b1) fs_cnt++;
      if (vif.locked === 1'b1) lock_hi++;
      if (vif.locked === 1'b1 && !lock_q) lock_rise_at = (vif.frame_start === 1'b1) ? fs_cnt : 99;
      if (vif.video_on === 1'b1) begin
         if (!von_q) begin
            rises++;
            run = 0;
            first_off = cyc - line_t0 - 1;
            rise_px = int'(vif.pixel_x);
            if (rises == 1) begin
               py_first   = int'(vif.pixel_y);
               first_line = cur_line;
            end
            py_last   = int'(vif.pixel_y);
            last_line = cur_line;
         end
         run++;
         von_cnt++;
         last_off = cyc - line_t0 - 1;
         last_px  = int'(vif.pixel_x);
      end else if (von_q && run != 16) begin
         bad_runs++;
      end
      if (vif.locked === 1'b1 && vif.video_on === 1'b0 && (vif.pixel_x != 0 || vif.pixel_y != 0))
         zero_bad++;
      lock_q = (vif.locked === 1'b1);
      von_q  = (vif.video_on === 1'b1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vif.h_sync_in = 1'b1;
      vif.v_sync_in = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk_0);
      chk_all_zero("reset");
      rst = 1'b1;
      clr_stats();

      // Nominal timing from reset: lock on the third vsync fall.
      run_lines(0, 1, -1, 0);
      for (int f = 0; f < 3; f++) run_lines(0, 10, -1, 2);
      chk_eq("nom_h_total", int'(vif.h_total_meas), 25);
      chk_eq("nom_h_pulse", int'(vif.h_pulse_meas), 4);
      chk_eq("nom_v_total", int'(vif.v_total_meas), 11);
      chk_eq("nom_v_pulse", int'(vif.v_pulse_meas), 2);
      chk_eq("nom_errors", err_cnt, 0);
      chk_eq("nom_frame_starts", fs_cnt, 3);
      chk_eq("nom_lock_with_fs", lock_rise_at, 3);
      chk_eq("nom_locked", int'(vif.locked), 1);

      // One full locked frame: active window placement and coordinates.
      clr_stats();
      run_lines(0, 10, -1, 2);
      chk_eq("vid_on_clocks", von_cnt, 96);
      chk_eq("vid_lines", rises, 6);
      chk_eq("vid_bad_runs", bad_runs, 0);
      chk_eq("vid_first_n", first_off, 7);
      chk_eq("vid_last_n", last_off, 22);
      chk_eq("vid_px_first", rise_px, 0);
      chk_eq("vid_px_last", last_px, 15);
      chk_eq("vid_py_first", py_first, 0);
      chk_eq("vid_first_line", first_line, 4);
      chk_eq("vid_py_last", py_last, 5);
      chk_eq("vid_last_line", last_line, 9);
      chk_eq("vid_zero_outside", zero_bad, 0);
      chk_eq("vid_errors", err_cnt, 0);

      // One stretched line while locked.
      clr_stats();
      run_lines(0, 6, 5, 2);
      chk_eq("str_h_total", int'(vif.h_total_meas), 26);
      chk_eq("str_err_drops_lock", err_drop, 1);
      chk_eq("str_locked", int'(vif.locked), 0);
      run_lines(7, 10, -1, 2);
      chk_eq("str_single_err", err_cnt, 1);
      clr_stats();
      run_lines(0, 10, -1, 2);
      run_lines(0, 10, -1, 2);
      chk_eq("str_not_yet_relocked", int'(vif.locked), 0);
      run_lines(0, 10, -1, 2);
      chk_eq("relock_with_fs", lock_rise_at, 3);
      chk_eq("relock_errors", err_cnt, 0);
      chk_eq("relock_locked", int'(vif.locked), 1);

      // Hsync stuck high while locked.
      clr_stats();
      repeat (4200) tick(1'b1, 1'b1);
      chk_eq("to_err_count", err_cnt, 1);
      chk_eq("to_err_at_n", err_off, 4095);
      chk_eq("to_err_drops_lock", err_drop, 1);
      chk_eq("to_locked", int'(vif.locked), 0);
      chk_eq("to_video_on", int'(vif.video_on), 0);

      // Reset pulse mid-line with hsync held low.
      run_lines(0, 1, -1, 0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      @(negedge clk_0);
      rst = 1'b0;
      @(negedge clk_0);
      rst = 1'b1;
      chk_all_zero("midrst");
      clr_stats();
      repeat (3) tick(1'b0, 1'b1);
      repeat (20) tick(1'b1, 1'b1);
      chk_eq("midrst_no_pulse", int'(vif.h_pulse_meas), 0);
      chk_eq("midrst_no_total", int'(vif.h_total_meas), 0);
      chk_eq("midrst_no_err", err_cnt, 0);
      run_lines(0, 1, -1, 0);
      chk_eq("midrst_h_total", int'(vif.h_total_meas), 25);
      chk_eq("midrst_h_pulse", int'(vif.h_pulse_meas), 4);
      chk_eq("midrst_err", err_cnt, 0);

      // Three-line vsync pulse: one error per frame, never locks.
      clr_stats();
      for (int f = 0; f < 4; f++) run_lines(0, 10, -1, 3);
      chk_eq("vw3_v_pulse", int'(vif.v_pulse_meas), 3);
      chk_eq("vw3_v_total", int'(vif.v_total_meas), 11);
      chk_eq("vw3_errors", err_cnt, 4);
      chk_eq("vw3_frame_starts", fs_cnt, 4);
      chk_eq("vw3_never_locked", lock_hi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
